// File: rtl/key_event_queue.sv
// Debounces the keypad level bus into one 4-bit event per press, queued in a small FIFO for the vending FSM.
// Latency: STABLE_CYCLES+2 clocks from key_value change to evt_valid (empty FIFO); head is registered.
// Backpressure: evt_ready low holds the head; a push into a full FIFO without a pop is dropped and sets sticky ovf.
// Optional: KEY_EVT_MULTI_ERR_EN turns stable multi-hot presses into a multi_err pulse instead of an event.
module key_event_queue #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       key_value,
    output logic             evt_valid,
    output logic [3:0]       evt_code,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             multi_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0]    STAB_ONE  = SW'(1);
    localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t           state_q, state_d;
    logic [9:0]       key_q, key_p_q;
    logic [SW-1:0]    stab_q, stab_d;
    logic             push_q, push_d;
    logic [3:0]       push_code_q, push_code_d;
    logic [3:0]       low_idx;
    logic             same_key;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic             full, pop, push_ok;

`ifdef KEY_EVT_MULTI_ERR_EN
    logic merr_q, merr_d;
    logic multi_hot;
    assign multi_hot = (key_q & (key_q - 10'd1)) != 10'd0;
    assign multi_err = merr_q;
`else
    assign multi_err = 1'b0;
`endif

    // Descending scan so the lowest set bit wins on multi-hot values.
    always_comb begin
        low_idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (key_q[i]) low_idx = 4'(i);
        end
    end

    assign same_key = (key_q == key_p_q);

    always_comb begin
        state_d     = state_q;
        stab_d      = stab_q;
        push_d      = 1'b0;
        push_code_d = push_code_q;
`ifdef KEY_EVT_MULTI_ERR_EN
        merr_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (key_q != 10'd0) begin
                    state_d = S_DEBOUNCE;
                    stab_d  = STAB_ONE;
                end
            end
            S_DEBOUNCE: begin
                if (key_q == 10'd0) begin
                    state_d = S_IDLE;
                    stab_d  = '0;
                end else if (!same_key) begin
                    stab_d = STAB_ONE;
                end else if (stab_q == STAB_LAST) begin
                    state_d = S_HELD;
                    stab_d  = '0;
`ifdef KEY_EVT_MULTI_ERR_EN
                    if (multi_hot) begin
                        merr_d = 1'b1;
                    end else begin
                        push_d      = 1'b1;
                        push_code_d = low_idx;
                    end
`else
                    push_d      = 1'b1;
                    push_code_d = low_idx;
`endif
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            S_HELD: begin
                // Any nonzero value, even another key, is ignored until a full release.
                if (key_q == 10'd0) begin
                    state_d = S_RELEASE;
                    stab_d  = STAB_ONE;
                end
            end
            S_RELEASE: begin
                if (key_q != 10'd0) begin
                    state_d = S_HELD;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = S_IDLE;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                stab_d  = '0;
            end
        endcase
    end

    assign full      = (count_q == DEPTH_C);
    assign evt_valid = (count_q != '0);
    assign evt_code  = evt_valid ? mem_q[rd_ptr_q] : 4'd0;
    assign evt_count = count_q;
    assign ovf       = ovf_q;
    assign pop       = evt_valid && evt_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok   = push_q && (!full || pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push_q && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            key_p_q     <= '0;
            stab_q      <= '0;
            push_q      <= 1'b0;
            push_code_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_value;
            key_p_q     <= key_q;
            stab_q      <= stab_d;
            push_q      <= push_d;
            push_code_q <= push_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef KEY_EVT_MULTI_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            merr_q <= 1'b0;
        end else begin
            merr_q <= merr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_code_q;
    end

endmodule
